// File: rtl/fifo_pkg.sv
// fifo_pkg: widths and depths shared by the async FIFO read side and its stream adapter
package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int BUF_DEPTH  = 4;
    localparam int BUF_PTR_W  = 2;
    localparam int CNT_W      = 16;
endpackage

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: 4-entry circular buffer holding words read from the FIFO until the stream pops them
//   i_clk/i_rst  clock and sync active-high reset
//   i_flush      drop all entries at the next edge
//   i_push/i_data  write one word at the tail
//   i_pop        remove the head word (ignored when empty)
//   o_count      occupancy 0..4, o_valid = non-empty, o_data = head word or 0 when empty
module fifo_rd_buf #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [fifo_pkg::BUF_PTR_W:0]  o_count,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data
);
    import fifo_pkg::*;

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [BUF_PTR_W-1:0]  r_wr_ptr;
    logic [BUF_PTR_W-1:0]  r_rd_ptr;
    logic [BUF_PTR_W:0]    r_count;
    logic                  w_pop;

    assign o_valid = r_count != '0;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
    assign w_pop   = i_pop && o_valid;

    // Storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{BUF_PTR_W{1'b0}}, i_push} - {{BUF_PTR_W{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts the FIFO rd_en/empty/registered-data port into a valid/ready stream
//   clkb/rstb   read-domain clock and sync active-high reset (shared with the FIFO read side)
//   fifo_empty/fifo_data/fifo_rd_en  FIFO read port; data arrives the cycle after an accepted read
//   flush       drop buffered and in-flight words at the next edge
//   m_data/m_valid/m_ready  output stream
//   buf_count   buffer occupancy 0..4, word_cnt  wrapping count of delivered words
module fifo_rd_stream #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = fifo_pkg::BUF_DEPTH
) (
    input  logic                          clkb,
    input  logic                          rstb,
    input  logic                          fifo_empty,
    input  logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_rd_en,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [fifo_pkg::BUF_PTR_W:0]  buf_count,
    output logic [fifo_pkg::CNT_W-1:0]    word_cnt
);
    import fifo_pkg::*;

    logic                 r_pending;
    logic [CNT_W-1:0]     r_word_cnt;
    logic                 w_room;

    // Reserve a slot for the in-flight word so a read is only issued when it is sure to fit;
    // only registered state is used, keeping m_ready off the rd_en path.
    assign w_room     = (buf_count + {{BUF_PTR_W{1'b0}}, r_pending}) < (BUF_PTR_W+1)'(BUF_DEPTH);
    assign fifo_rd_en = !rstb && !flush && !fifo_empty && w_room;
    assign word_cnt   = r_word_cnt;

    always_ff @(posedge clkb) begin
        if (rstb || flush) r_pending <= 1'b0;
        else r_pending <= fifo_rd_en && !fifo_empty;
    end

    always_ff @(posedge clkb) begin
        if (rstb) r_word_cnt <= '0;
        else if (m_valid && m_ready) r_word_cnt <= r_word_cnt + CNT_W'(1);
    end

    fifo_rd_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .i_clk   (clkb),
        .i_rst   (rstb),
        .i_flush (flush),
        .i_push  (r_pending),
        .i_data  (fifo_data),
        .i_pop   (m_ready),
        .o_count (buf_count),
        .o_valid (m_valid),
        .o_data  (m_data)
    );
endmodule
